// File: rtl/mb_clk_pattern_gen.sv
// mb_clk_pattern_gen
// Mainband clock-gate pattern generator for the UCIe clock TX path.
// On a training request it drives per-lane gate enables through a
// programmable number of ON/OFF iterations, then goes free-running or idle
// depending on the latched mode. Abort (i_stop / i_ltsm_in_reset) always
// wins and returns the block to IDLE with gates low.
//
// Optional feature macro: CLKGEN_DEBUG_CNT_EN
//   When defined, adds o_iter_done, the number of iterations completed in
//   the current or most recent training run.
module mb_clk_pattern_gen #(
  parameter int NUM_LANES = 3,
  parameter int ON_CYC    = 2,
  parameter int OFF_CYC   = 1,
  parameter int ITER_W    = 8
) (
  input  logic                 i_dig_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [1:0]           i_mode,
  input  logic [ITER_W-1:0]    i_iter_count,
  input  logic [NUM_LANES-1:0] i_lane_mask,
  input  logic                 i_stop,
  input  logic                 i_ltsm_in_reset,
  output logic [NUM_LANES-1:0] o_clk_gate_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
`ifdef CLKGEN_DEBUG_CNT_EN
  ,
  output logic [ITER_W-1:0]    o_iter_done
`endif
);

  localparam int PERIOD = ON_CYC + OFF_CYC;
  localparam int PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_ON   = PH_W'(ON_CYC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_FREE  = 2'd2
  } state_e;

  state_e               cs, ns;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [ITER_W-1:0]    iter_q, iter_d;
  logic [ITER_W-1:0]    cnt_q, cnt_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic                 to_free_q, to_free_d;
  logic [NUM_LANES-1:0] gate_d;
  logic                 done_d, err_d;

  logic abort;
  logic last_phase;
  logic last_iter;

  assign abort      = i_stop | i_ltsm_in_reset;
  assign last_phase = (phase_q == PH_LAST);
  // Exit happens at equality, so the iteration counter never wraps.
  assign last_iter  = (iter_q == (cnt_q - ITER_W'(1)));

  // Busy is a pure function of the registered state.
  assign o_busy = (cs != ST_IDLE);

  // Next-state, counter and registered-output computation.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    ns        = cs;
    phase_d   = phase_q;
    iter_d    = iter_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    to_free_d = to_free_q;
    gate_d    = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (abort) begin
      // Abort beats start and completion; gates drop the next cycle.
      ns      = ST_IDLE;
      phase_d = '0;
      iter_d  = '0;
    end else begin
      unique case (cs)
        ST_IDLE: begin
          phase_d = '0;
          iter_d  = '0;
          if (i_start) begin
            if (i_mode == 2'b10) begin
              ns     = ST_FREE;
              mask_d = i_lane_mask;
              gate_d = i_lane_mask;
            end else if (i_iter_count == '0) begin
              err_d = 1'b1;
            end else begin
              // Modes 01 and 11 both end in IDLE; only 00 continues to FREE.
              ns        = ST_TRAIN;
              cnt_d     = i_iter_count;
              mask_d    = i_lane_mask;
              to_free_d = (i_mode == 2'b00);
              gate_d    = i_lane_mask;  // phase 0 is always an ON phase
            end
          end
        end

        ST_TRAIN: begin
          if (last_phase) begin
            phase_d = '0;
            if (last_iter) begin
              done_d = 1'b1;
              iter_d = '0;
              if (to_free_q) begin
                ns     = ST_FREE;
                gate_d = mask_q;
              end else begin
                ns = ST_IDLE;
              end
            end else begin
              iter_d = iter_q + ITER_W'(1);
              gate_d = mask_q;
            end
          end else begin
            phase_d = phase_q + PH_W'(1);
            gate_d  = (phase_d < PH_ON) ? mask_q : '0;
          end
        end

        ST_FREE: begin
          gate_d = mask_q;
        end

        default: begin
          ns = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters, latched configuration and registered outputs.
  always_ff @(posedge i_dig_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cs            <= ST_IDLE;
      phase_q       <= '0;
      iter_q        <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      to_free_q     <= 1'b0;
      o_clk_gate_en <= '0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
      cs            <= ns;
      phase_q       <= phase_d;
      iter_q        <= iter_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      to_free_q     <= to_free_d;
      o_clk_gate_en <= gate_d;
      o_done        <= done_d;
      o_err         <= err_d;
    end
  end

`ifdef CLKGEN_DEBUG_CNT_EN
  logic start_accept;
  assign start_accept = (cs == ST_IDLE) && i_start && !abort &&
                        ((i_mode == 2'b10) || (i_iter_count != '0));

  // Completed-iteration count, held after training until the next accepted start.
  always_ff @(posedge i_dig_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_iter_done <= '0;
    end else if (start_accept) begin
      o_iter_done <= '0;
    end else if ((cs == ST_TRAIN) && !abort && last_phase) begin
      o_iter_done <= o_iter_done + ITER_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mb_clk_pattern_gen.sv
// Self-checking bench for mb_clk_pattern_gen. Expected gate patterns come
// from a cycle-index model: during training, cycle k after the start shows
// the mask when (k mod (ON_CYC+OFF_CYC)) < ON_CYC, else zero.
module tb_mb_clk_pattern_gen;

  localparam int NUM_LANES = 3;
  localparam int ON_CYC    = 2;
  localparam int OFF_CYC   = 1;
  localparam int ITER_W    = 8;
  localparam int PERIOD    = ON_CYC + OFF_CYC;

  logic                 i_dig_clk = 1'b0;
  logic                 i_rst_n;
  logic                 i_start;
  logic [1:0]           i_mode;
  logic [ITER_W-1:0]    i_iter_count;
  logic [NUM_LANES-1:0] i_lane_mask;
  logic                 i_stop;
  logic                 i_ltsm_in_reset;
  logic [NUM_LANES-1:0] o_clk_gate_en;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;
`ifdef CLKGEN_DEBUG_CNT_EN
  logic [ITER_W-1:0]    o_iter_done;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_dig_clk = ~i_dig_clk;

  mb_clk_pattern_gen #(
    .NUM_LANES(NUM_LANES),
    .ON_CYC   (ON_CYC),
    .OFF_CYC  (OFF_CYC),
    .ITER_W   (ITER_W)
  ) dut (
    .i_dig_clk      (i_dig_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_mode         (i_mode),
    .i_iter_count   (i_iter_count),
    .i_lane_mask    (i_lane_mask),
    .i_stop         (i_stop),
    .i_ltsm_in_reset(i_ltsm_in_reset),
    .o_clk_gate_en  (o_clk_gate_en),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
`ifdef CLKGEN_DEBUG_CNT_EN
    ,
    .o_iter_done    (o_iter_done)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [NUM_LANES-1:0] gate,
                            input logic busy, input logic done, input logic err);
    check({tag, ".gate"}, 32'(o_clk_gate_en), 32'(gate));
    check({tag, ".busy"}, 32'(o_busy), 32'(busy));
    check({tag, ".done"}, 32'(o_done), 32'(done));
    check({tag, ".err"},  32'(o_err),  32'(err));
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge i_dig_clk);
    #1;
  endtask

  function automatic logic [NUM_LANES-1:0] pat(input int k, input logic [NUM_LANES-1:0] mask);
    return ((k % PERIOD) < ON_CYC) ? mask : '0;
  endfunction

  // Start a training run and check every cycle against the pattern model.
  // abort_k >= 0 raises i_stop in training cycle abort_k. On normal return
  // the bench sits in the cycle carrying o_done.
  task automatic run_train(input logic [1:0] mode, input int count,
                           input logic [NUM_LANES-1:0] mask, input int abort_k,
                           input string tag);
    int total;
    total        = count * PERIOD;
    i_start      = 1'b1;
    i_mode       = mode;
    i_iter_count = ITER_W'(count);
    i_lane_mask  = mask;
    cyc();
    for (int k = 0; k < total; k++) begin
      check_outs(tag, pat(k, mask), 1'b1, 1'b0, 1'b0);
      // Inputs wiggle while busy; the run must ignore them.
      i_start      = 1'($urandom);
      i_mode       = 2'($urandom);
      i_iter_count = ITER_W'($urandom);
      i_lane_mask  = NUM_LANES'($urandom);
      if (k == abort_k) begin
        i_stop = 1'b1;
        cyc();
        i_stop  = 1'b0;
        i_start = 1'b0;
        check_outs({tag, ".abort"}, '0, 1'b0, 1'b0, 1'b0);
        return;
      end
      cyc();
    end
    i_start = 1'b0;
    check_outs({tag, ".fin"}, (mode == 2'b00) ? mask : '0, (mode == 2'b00), 1'b1, 1'b0);
`ifdef CLKGEN_DEBUG_CNT_EN
    check({tag, ".iter_done"}, 32'(o_iter_done), 32'(count));
`endif
  endtask

  initial begin
    i_rst_n         = 1'b0;
    i_start         = 1'b0;
    i_mode          = 2'b00;
    i_iter_count    = '0;
    i_lane_mask     = '0;
    i_stop          = 1'b0;
    i_ltsm_in_reset = 1'b0;

    // Reset state.
    #12;
    check_outs("reset", '0, 1'b0, 1'b0, 1'b0);
    @(negedge i_dig_clk);
    i_rst_n = 1'b1;
    cyc();
    check_outs("idle", '0, 1'b0, 1'b0, 1'b0);

    // Zero count in a training mode is rejected with a one-cycle error.
    i_start = 1'b1; i_mode = 2'b00; i_iter_count = '0; i_lane_mask = 3'b111;
    cyc();
    i_start = 1'b0;
    check_outs("cnt0", '0, 1'b0, 1'b0, 1'b1);
    cyc();
    check_outs("cnt0.after", '0, 1'b0, 1'b0, 1'b0);

    // Mode 00, 128 iterations, then free-run until LTSM reset.
    run_train(2'b00, 128, 3'b111, -1, "m00");
    repeat (5) begin
      cyc();
      check_outs("m00.free", 3'b111, 1'b1, 1'b0, 1'b0);
    end
    i_ltsm_in_reset = 1'b1;
    cyc();
    i_ltsm_in_reset = 1'b0;
    check_outs("m00.ltsm", '0, 1'b0, 1'b0, 1'b0);

    // Mode 01 with lane 1 masked, then a back-to-back start in the done cycle (mode 11).
    run_train(2'b01, 3, 3'b101, -1, "m01");
    run_train(2'b11, 2, 3'b110, -1, "m11_b2b");
    cyc();
    check_outs("m11.idle", '0, 1'b0, 1'b0, 1'b0);

    // Stop in the same cycle as final-phase completion: no done, gates low.
    run_train(2'b00, 2, 3'b111, 2 * PERIOD - 1, "stop_last");
    cyc();
    check_outs("stop_last.idle", '0, 1'b0, 1'b0, 1'b0);

    // Abort beats a start (including a would-be error) in IDLE.
    i_start = 1'b1; i_mode = 2'b00; i_iter_count = '0; i_stop = 1'b1;
    cyc();
    check_outs("abort_vs_err", '0, 1'b0, 1'b0, 1'b0);
    i_mode = 2'b10; i_lane_mask = 3'b111;
    cyc();
    check_outs("abort_vs_free", '0, 1'b0, 1'b0, 1'b0);
    i_start = 1'b0; i_stop = 1'b0;

    // Mode 10: immediate free-run with mask 011; starts while busy ignored.
    i_start = 1'b1; i_mode = 2'b10; i_lane_mask = 3'b011; i_iter_count = '0;
    cyc();
    for (int k = 0; k < 12; k++) begin
      check_outs("m10", 3'b011, 1'b1, 1'b0, 1'b0);
      i_start      = 1'($urandom);
      i_mode       = 2'($urandom);
      i_iter_count = ITER_W'($urandom);
      i_lane_mask  = NUM_LANES'($urandom);
      cyc();
    end
    i_start = 1'b0; i_stop = 1'b1;
    cyc();
    i_stop = 1'b0;
    check_outs("m10.stop", '0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset at iteration 5 of a training run.
    i_start = 1'b1; i_mode = 2'b00; i_iter_count = 8'd10; i_lane_mask = 3'b111;
    cyc();
    i_start = 1'b0;
    repeat (5 * PERIOD) cyc();
    check("rst.pre_gate", 32'(o_clk_gate_en), 32'(3'b111));
    i_rst_n = 1'b0;
    #1;
    check_outs("rst.async", '0, 1'b0, 1'b0, 1'b0);
    #4;
    i_rst_n = 1'b1;
    cyc();
    check_outs("rst.idle", '0, 1'b0, 1'b0, 1'b0);
    run_train(2'b01, 1, 3'b010, -1, "post_rst");
    cyc();
    check_outs("post_rst.idle", '0, 1'b0, 1'b0, 1'b0);

    // Randomized training runs with occasional aborts.
    for (int t = 0; t < 10; t++) begin
      int          r;
      int          c;
      int          ak;
      logic [1:0]  m;
      logic [NUM_LANES-1:0] mk;
      r  = int'($urandom_range(0, 2));
      m  = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
      c  = int'($urandom_range(1, 6));
      mk = NUM_LANES'($urandom);
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c * PERIOD - 1)) : -1;
      run_train(m, c, mk, ak, $sformatf("rnd%0d", t));
      i_stop = 1'b1;
      cyc();
      i_stop = 1'b0;
      check_outs($sformatf("rnd%0d.end", t), '0, 1'b0, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
